// File: rtl/memchk_pkg.sv
// Shared types and constants for the memory-write checker.
// State encoding, failure cause codes and an index-width helper.
package memchk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } memchk_state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ADDR    = 2'd1;
    localparam logic [1:0] FC_DATA    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

    // A single-entry table still needs a one-bit index port.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/memchk_table.sv
// Expected-store table: DEPTH entries of (address, data).
// It has one write port, one combinational read port, and an async clear.
module memchk_table
    import memchk_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    localparam int IW   = idx_width(DEPTH)
) (
    input  logic          clka,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic [IW-1:0] rd_idx,
    output logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_idx) < DEPTH)) begin
            addr_mem[cfg_idx] <= cfg_addr;
            data_mem[cfg_idx] <= cfg_data;
        end
    end

    // Indices past the last entry (non power-of-two DEPTH) read as zero.
    always_comb begin
        rd_addr = '0;
        rd_data = '0;
        if (int'(rd_idx) < DEPTH) begin
            rd_addr = addr_mem[rd_idx];
            rd_data = data_mem[rd_idx];
        end
    end

endmodule

// File: rtl/memwrite_checker.sv
// Store monitor: matches CPU data-memory writes, in order, against a loadable table.
// Define MEMCHK_TIMEOUT_EN to add a run-cycle watchdog that fails with FC_TIMEOUT.
module memwrite_checker
    import memchk_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096,
    localparam int IW     = idx_width(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clka,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic [AW-1:0] tol_lo,
    input  logic [AW-1:0] tol_hi,
    input  logic [CW-1:0] num_exp,
    input  logic          start,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    fail_code,
    output logic [CW-1:0] match_cnt,
    output logic [AW-1:0] err_addr,
    output logic [DW-1:0] err_data
);

    if (DEPTH < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("memwrite_checker: DEPTH and TIMEOUT must both be at least 1");
    end

    memchk_state_t state, state_next;

    logic [CW-1:0] ptr;
    logic [CW-1:0] ptr_inc;
    logic [CW-1:0] num_lat;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          addr_hit;
    logic          data_hit;
    logic          in_window;
    logic          store_match;
    logic          store_last;
    logic          store_bad;
    logic [1:0]    store_code;
    logic          timeout_hit;

    // The table is frozen while a run is in progress.
    memchk_table #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_table (
        .clka     (clka),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we && (state != ST_RUN)),
        .cfg_idx  (cfg_idx),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .rd_idx   (ptr[IW-1:0]),
        .rd_addr  (exp_addr),
        .rd_data  (exp_data)
    );

`ifdef MEMCHK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (start) begin
            timer <= '0;
        end else if (state == ST_RUN) begin
            timer <= timer + TW'(1);
        end
    end

    assign timeout_hit = (timer == TW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Classify the store presented this cycle against the next expected entry.
    always_comb begin
        addr_hit    = (dataadr == exp_addr);
        data_hit    = (writedata == exp_data);
        in_window   = (dataadr >= tol_lo) && (dataadr <= tol_hi);
        ptr_inc     = ptr + CW'(1);
        store_match = memwrite && addr_hit && data_hit;
        store_last  = store_match && (ptr_inc == num_lat);
        store_bad   = 1'b0;
        store_code  = FC_NONE;
        if (memwrite && addr_hit && !data_hit) begin
            store_bad  = 1'b1;
            store_code = FC_DATA;
        end else if (memwrite && !addr_hit && !in_window) begin
            store_bad  = 1'b1;
            store_code = FC_ADDR;
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A store that settles the run outranks a timeout on the same edge.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = (num_exp == '0) ? ST_PASS : ST_RUN;
        end else if (state == ST_RUN) begin
            if (store_last) begin
                state_next = ST_PASS;
            end else if (store_bad || timeout_hit) begin
                state_next = ST_FAIL;
            end
        end
    end

    always_comb begin
        busy = (state == ST_RUN);
        pass = (state == ST_PASS);
        fail = (state == ST_FAIL);
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            num_lat   <= '0;
            fail_code <= FC_NONE;
            err_addr  <= '0;
            err_data  <= '0;
        end else if (start) begin
            ptr       <= '0;
            num_lat   <= num_exp;
            fail_code <= FC_NONE;
            err_addr  <= '0;
            err_data  <= '0;
        end else if (state == ST_RUN) begin
            if (store_match) begin
                ptr <= ptr_inc;
            end
            if (store_bad) begin
                fail_code <= store_code;
                err_addr  <= dataadr;
                err_data  <= writedata;
            end else if (timeout_hit && !store_last) begin
                fail_code <= FC_TIMEOUT;
            end
        end
    end

    assign match_cnt = ptr;

endmodule

// File: tb/tb_memwrite_checker.sv
// Randomized bench for memwrite_checker against a transaction-level store model.
// Build with MEMCHK_TIMEOUT_EN defined to cover the watchdog path as well.
module tb_memwrite_checker;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int IW      = 3;
    localparam int CW      = 4;

`ifdef MEMCHK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PASS = 2;
    localparam int M_FAIL = 3;

    logic          clka;
    logic          rst_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic [AW-1:0] tol_lo;
    logic [AW-1:0] tol_hi;
    logic [CW-1:0] num_exp;
    logic          start;
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          busy;
    logic          pass;
    logic          fail;
    logic [1:0]    fail_code;
    logic [CW-1:0] match_cnt;
    logic [AW-1:0] err_addr;
    logic [DW-1:0] err_data;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] m_tab_a [DEPTH];
    logic [DW-1:0] m_tab_d [DEPTH];
    int            m_mode;
    int            m_cnt;
    int            m_num;
    int            m_cycles;
    int            m_code;
    logic [AW-1:0] m_ea;
    logic [DW-1:0] m_ed;

    memwrite_checker #(
        .AW      (AW),
        .DW      (DW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clka      (clka),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .tol_lo    (tol_lo),
        .tol_hi    (tol_hi),
        .num_exp   (num_exp),
        .start     (start),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .busy      (busy),
        .pass      (pass),
        .fail      (fail),
        .fail_code (fail_code),
        .match_cnt (match_cnt),
        .err_addr  (err_addr),
        .err_data  (err_data)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            m_tab_a[i] = '0;
            m_tab_d[i] = '0;
        end
        m_mode   = M_IDLE;
        m_cnt    = 0;
        m_num    = 0;
        m_cycles = 0;
        m_code   = 0;
        m_ea     = '0;
        m_ed     = '0;
    endtask

    // One clock edge of the checker, expressed as store-sequence rules.
    task automatic modelEdge();
        int prev;
        prev = m_mode;
        if (start) begin
            m_cnt    = 0;
            m_cycles = 0;
            m_code   = 0;
            m_ea     = '0;
            m_ed     = '0;
            m_num    = int'(num_exp);
            m_mode   = (m_num == 0) ? M_PASS : M_RUN;
        end else if (m_mode == M_RUN) begin
            m_cycles++;
            if (memwrite) begin
                if (dataadr == m_tab_a[m_cnt]) begin
                    if (writedata == m_tab_d[m_cnt]) begin
                        m_cnt++;
                        if (m_cnt == m_num) m_mode = M_PASS;
                    end else begin
                        m_mode = M_FAIL;
                        m_code = 2;
                        m_ea   = dataadr;
                        m_ed   = writedata;
                    end
                end else if (!(dataadr >= tol_lo && dataadr <= tol_hi)) begin
                    m_mode = M_FAIL;
                    m_code = 1;
                    m_ea   = dataadr;
                    m_ed   = writedata;
                end
            end
            if (m_mode == M_RUN && TO_EN && m_cycles >= TIMEOUT) begin
                m_mode = M_FAIL;
                m_code = 3;
            end
        end
        if (cfg_we && prev != M_RUN) begin
            m_tab_a[cfg_idx] = cfg_addr;
            m_tab_d[cfg_idx] = cfg_data;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".busy"}, busy, m_mode == M_RUN);
        checkOutput({tag, ".pass"}, pass, m_mode == M_PASS);
        checkOutput({tag, ".fail"}, fail, m_mode == M_FAIL);
        checkOutput({tag, ".fail_code"}, fail_code, m_code);
        checkOutput({tag, ".match_cnt"}, match_cnt, m_cnt);
        checkOutput({tag, ".err_addr"}, err_addr, m_ea);
        checkOutput({tag, ".err_data"}, err_data, m_ed);
    endtask

    // Clock the inputs currently driven, then compare against the model.
    task automatic applyStimulus(input string tag);
        @(posedge clka);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    task automatic loadEntry(input int idx, input int a, input int d);
        cfg_we   = 1'b1;
        cfg_idx  = IW'(idx);
        cfg_addr = AW'(a);
        cfg_data = DW'(d);
        applyStimulus("load");
        cfg_we   = 1'b0;
    endtask

    task automatic startRun(input int n);
        num_exp = CW'(n);
        start   = 1'b1;
        applyStimulus("start");
        start   = 1'b0;
    endtask

    task automatic doStore(input int a, input int d);
        memwrite  = 1'b1;
        dataadr   = AW'(a);
        writedata = DW'(d);
        applyStimulus("store");
        memwrite  = 1'b0;
    endtask

    initial begin
        int n;
        int kind;
        int lo;
        int hi;
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        tol_lo = '0; tol_hi = '0; num_exp = '0; start = 1'b0;
        memwrite = 1'b0; dataadr = '0; writedata = '0;
        modelReset();
        #12;
        checkAll("reset");
        @(negedge clka);
        rst_n = 1'b1;

        loadEntry(0, 84, 7);
        tol_lo = 80; tol_hi = 80;
        startRun(1);
        doStore(80, 3);
        doStore(80, 5);
        checkOutput("t1_still_busy", busy, 1);
        doStore(84, 7);
        checkOutput("t1_pass", pass, 1);
        checkOutput("t1_cnt", match_cnt, 1);

        startRun(1);
        doStore(80, 3);
        doStore(88, 7);
        checkOutput("t2_fail", fail, 1);
        checkOutput("t2_code", fail_code, 1);
        checkOutput("t2_eaddr", err_addr, 88);
        checkOutput("t2_edata", err_data, 7);

        startRun(1);
        doStore(84, 6);
        checkOutput("t3_code", fail_code, 2);
        checkOutput("t3_edata", err_data, 6);

        loadEntry(0, 4, 1);
        loadEntry(1, 8, 2);
        loadEntry(2, 12, 3);
        startRun(3);
        doStore(4, 1);
        doStore(8, 2);
        doStore(12, 3);
        checkOutput("t4_pass", pass, 1);
        checkOutput("t4_cnt", match_cnt, 3);
        tol_lo = 1; tol_hi = 0;
        startRun(3);
        doStore(8, 2);
        checkOutput("t4_code", fail_code, 1);
        checkOutput("t4_eaddr", err_addr, 8);

        startRun(3);
        repeat (TIMEOUT - 1) applyStimulus("idle");
        checkOutput("t5_busy_before", busy, 1);
        applyStimulus("idle");
        if (TO_EN) begin
            checkOutput("t5_timeout_code", fail_code, 3);
            checkOutput("t5_timeout_fail", fail, 1);
        end else begin
            checkOutput("t5_no_timeout", busy, 1);
        end

        startRun(3);
        doStore(4, 1);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("midreset");
        checkOutput("t5_rst_cnt", match_cnt, 0);
        @(negedge clka);
        rst_n = 1'b1;

        startRun(0);
        checkOutput("t6_zero_pass", pass, 1);
        loadEntry(0, 4, 1);
        num_exp   = 1;
        start     = 1'b1;
        memwrite  = 1'b1;
        dataadr   = 4;
        writedata = 1;
        applyStimulus("start_store");
        start     = 1'b0;
        memwrite  = 1'b0;
        checkOutput("t6_ignored_cnt", match_cnt, 0);
        checkOutput("t6_busy", busy, 1);

        for (int run = 0; run < 30; run++) begin
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) begin
                loadEntry(i, int'($urandom_range(0, 15)) * 4, int'($urandom_range(0, 3)));
            end
            lo = int'($urandom_range(0, 15)) * 4;
            hi = lo + int'($urandom_range(0, 3)) * 4;
            if ($urandom_range(0, 4) == 0) begin
                tol_lo = AW'(hi + 4);
                tol_hi = AW'(lo);
            end else begin
                tol_lo = AW'(lo);
                tol_hi = AW'(hi);
            end
            startRun(n);
            for (int c = 0; c < 40 && m_mode == M_RUN; c++) begin
                kind = int'($urandom_range(0, 9));
                if (kind <= 4) begin
                    memwrite  = 1'b1;
                    dataadr   = m_tab_a[m_cnt];
                    writedata = m_tab_d[m_cnt];
                end else if (kind <= 6) begin
                    memwrite  = 1'b1;
                    dataadr   = AW'($urandom_range(0, 15) * 4);
                    writedata = DW'($urandom_range(0, 3));
                end else if (kind == 8) begin
                    cfg_we   = 1'b1;
                    cfg_idx  = IW'($urandom_range(0, DEPTH - 1));
                    cfg_addr = AW'($urandom_range(0, 63));
                    cfg_data = DW'($urandom_range(0, 3));
                end else if (kind == 9) begin
                    memwrite  = 1'b1;
                    dataadr   = m_tab_a[m_cnt];
                    writedata = m_tab_d[m_cnt] ^ DW'(1);
                end
                applyStimulus("rand");
                memwrite = 1'b0;
                cfg_we   = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memwrite_checker.md
# memwrite_checker

Self-checking store monitor for the pipelined CPU simulation environment. It watches the data-memory write port (`memwrite`, `dataadr`, `writedata`) and checks it against a loadable table of expected `(address, data)` stores, which must occur in order. It reports sticky pass/fail status with a cause code, so any bench can stop on a verdict without hard-coded compare logic. It sits beside `top` in the testbench and is also synthesizable for on-board self-test.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `DEPTH`, 8, expected-table entries (≥1)
- `TIMEOUT`, 4096, run-cycle budget before a timeout failure (≥1)
- `clka` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `cfg_we` in 1 — write table entry
- `cfg_idx` in $clog2(DEPTH) — entry index
- `cfg_addr` in AW — expected store address
- `cfg_data` in DW — expected store data
- `tol_lo`, `tol_hi` in AW each — inclusive tolerated-address window; stores here are ignored
- `num_exp` in $clog2(DEPTH+1) — entries to match, sampled on `start`
- `start` in 1 — begin/restart a check run
- `memwrite` in 1 — CPU store strobe
- `dataadr` in AW — store address
- `writedata` in DW — store data
- `busy` out 1 — run in progress
- `pass` out 1 — sticky success
- `fail` out 1 — sticky failure
- `fail_code` out 2 — 0 none, 1 address, 2 data, 3 timeout
- `match_cnt` out $clog2(DEPTH+1) — entries matched so far
- `err_addr` out AW — address of the offending store
- `err_data` out DW — data of the offending store

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE→RUN on `start`. On that edge, clear `ptr`, `match_cnt`, the timer and the error fields, and latch `num_exp`. If the latched value is 0, go straight to PASS instead.
- RUN, `memwrite`=1, all conditions sampled on the same edge:
  - `dataadr==exp_addr[ptr]` and `writedata==exp_data[ptr]` → `ptr++` and `match_cnt++`. If the new `ptr` equals `num_exp` → PASS.
  - Address matches but data differs → FAIL, code 2.
  - Address differs and `tol_lo ≤ dataadr ≤ tol_hi` (unsigned) → ignore the store.
  - Address differs and lies outside the window → FAIL, code 1.
- On FAIL, latch `err_addr`/`err_data` from the offending store.
- PASS and FAIL are sticky and exit only on `start` (restart) or reset.
- `start` in any state restarts the run. If `memwrite` is high in the same cycle, that store is ignored.
- `cfg_we` writes the table in any state except RUN; it is ignored during RUN.
- An empty window (`tol_lo > tol_hi`) tolerates nothing.

## Timing
- All outputs are registered, and every verdict appears on the edge after the deciding store.
- Reset values:
  - state IDLE
  - `busy`, `pass`, `fail` = 0
  - `fail_code` = 0
  - `match_cnt` = 0
  - `err_addr`, `err_data` = 0
  - table contents are reset to 0
- `busy`=1 exactly while in RUN.
- Asserting `rst_n` low during RUN aborts immediately to IDLE; no verdict is produced.
- The timer counts RUN cycles, including cycles without a store.

## Configuration
- `MEMCHK_TIMEOUT_EN` defined:
  - The timer is present.
  - After `TIMEOUT` cycles in RUN without reaching PASS → FAIL, code 3, with `err_addr`/`err_data` = 0.
  - A store that resolves the run on the same edge as the timeout takes priority.
- Undefined: no timer; RUN can last indefinitely, and code 3 is never produced.

## Structure
- Package `memchk_pkg`: state enum, `fail_code` constants (`FC_NONE`, `FC_ADDR`, `FC_DATA`, `FC_TIMEOUT`).
- Sub-module `memchk_table`: DEPTH×(AW+DW) register file. It has a write port (`cfg_*`), one combinational read port indexed by `ptr`, and asynchronous clear on `rst_n`.

## Test plan
- Table {(84,7)}, window [80,80], `num_exp`=1, start. Stores (80,3), (80,5), (84,7) → `pass`=1 the edge after the third store, `match_cnt`=1.
- Same setup, stores (80,3) then (88,7) → `fail`=1, `fail_code`=1, `err_addr`=88, `err_data`=7.
- Table {(84,7)}, store (84,6) → `fail_code`=2, `err_data`=6.
- Table {(4,1),(8,2),(12,3)}, `num_exp`=3, in-order stores → PASS. Restart, then (8,2) first with an empty window → FAIL code 1.
- With `MEMCHK_TIMEOUT_EN` and `TIMEOUT`=16, start with no stores → `fail_code`=3 on the 16th RUN edge. Also pulse `rst_n` low mid-run → state IDLE, all outputs 0.
- `num_exp`=0 with start → `pass` the next edge. Also `start` coincident with a matching `memwrite` → store ignored, `match_cnt`=0.
